// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that multiplexes NUM_DEV requesters onto one
// synchronous single-port RAM, with fixed-length pipelined read bursts.
module mem_arbiter_rr #(
  parameter int unsigned NUM_DEV   = 3,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_W    = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DEV-1:0]        dev_mem_en,
  input  logic [NUM_DEV-1:0]        dev_mem_we,
  input  logic [NUM_DEV-1:0]        dev_burst_en,
  input  logic [NUM_DEV*ADDR_W-1:0] dev_mem_addr,
  input  logic [NUM_DEV*DATA_W-1:0] dev_mem_di,
  input  logic [NUM_DEV*BANK_W-1:0] dev_bank_select,
  output logic [NUM_DEV-1:0]        dev_ack,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_di,
  output logic [BANK_W-1:0]         mem_bank_select,
  input  logic [DATA_W-1:0]         mem_do,
  output logic [DATA_W-1:0]         dev_mem_do
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;

  logic               issue_d;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  di_d;
  logic [BANK_W-1:0]  bank_d;
  logic [NUM_DEV-1:0] ack_d;

  logic [NUM_DEV-1:0] eligible;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic [31:0]        burst_off;
  logic [ADDR_W-1:0]  burst_addr;

  logic [ADDR_W-1:0]  dev_addr [NUM_DEV];
  logic [DATA_W-1:0]  dev_di   [NUM_DEV];
  logic [BANK_W-1:0]  dev_bank [NUM_DEV];

  // Unpack the flat per-device buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      dev_addr[i] = dev_mem_addr[i*ADDR_W +: ADDR_W];
      dev_di[i]   = dev_mem_di[i*DATA_W +: DATA_W];
      dev_bank[i] = dev_bank_select[i*BANK_W +: BANK_W];
    end
  end

  // A device whose beat was issued last cycle still holds its request awaiting ack.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      eligible[i] = dev_mem_en[i] & ~(mem_en & (owner_q == IDX_W'(i)));
    end
  end

  // Continuation address wraps modulo 2^ADDR_W.
  assign burst_off  = 32'(beat_cnt_q) * ADDR_STEP;
  assign burst_addr = ADDR_W'(32'(base_q) + burst_off);

  assign dev_mem_do = mem_do;

  // Next-state, arbitration and next beat selection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    base_d       = base_q;
    issue_d      = 1'b0;
    we_d         = 1'b0;
    addr_d       = '0;
    di_d         = '0;
    bank_d       = '0;
    found        = 1'b0;
    win          = '0;
    cand         = '0;
    ack_d        = '0;

    if (mem_en) begin
      ack_d[owner_q] = 1'b1;
    end

    if (state_q == BURST && dev_mem_en[owner_q] && beat_cnt_q < CNT_W'(BURST_LEN)) begin
      issue_d    = 1'b1;
      addr_d     = burst_addr;
      di_d       = dev_di[owner_q];
      bank_d     = dev_bank[owner_q];
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end else begin
      for (int unsigned k = 1; k <= NUM_DEV; k++) begin
        cand = IDX_W'((32'(last_grant_q) + k) % NUM_DEV);
        if (!found && eligible[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        issue_d      = 1'b1;
        owner_d      = win;
        last_grant_d = win;
        we_d         = dev_mem_we[win];
        addr_d       = dev_addr[win];
        di_d         = dev_di[win];
        bank_d       = dev_bank[win];
        if (dev_burst_en[win] && !dev_mem_we[win]) begin
          state_d    = BURST;
          beat_cnt_d = CNT_W'(1);
          base_d     = dev_addr[win];
        end else begin
          state_d    = SINGLE;
          beat_cnt_d = '0;
        end
      end else begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    end
  end

  // State and registered RAM/ack outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      last_grant_q    <= IDX_W'(NUM_DEV - 1);
      beat_cnt_q      <= '0;
      base_q          <= '0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_di          <= '0;
      mem_bank_select <= '0;
      dev_ack         <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      beat_cnt_q      <= beat_cnt_d;
      base_q          <= base_d;
      mem_en          <= issue_d;
      mem_we          <= we_d;
      mem_addr        <= addr_d;
      mem_di          <= di_d;
      mem_bank_select <= bank_d;
      dev_ack         <= ack_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed vector table plus randomized traffic
// checked against a transaction-level model with its own RAM image.
module tb_mem_arbiter_rr;

  localparam int unsigned NUM_DEV   = 3;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BANK_W    = 4;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned ADDR_STEP = 4;
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  logic                      clk;
  logic                      rst;
  logic [NUM_DEV-1:0]        t_en, t_we, t_bst;
  logic [ADDR_W-1:0]         t_addr [NUM_DEV];
  logic [DATA_W-1:0]         t_di   [NUM_DEV];
  logic [BANK_W-1:0]         t_bank [NUM_DEV];
  logic [NUM_DEV*ADDR_W-1:0] dev_mem_addr;
  logic [NUM_DEV*DATA_W-1:0] dev_mem_di;
  logic [NUM_DEV*BANK_W-1:0] dev_bank_select;
  logic [NUM_DEV-1:0]        dev_ack;
  logic                      mem_en, mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_di;
  logic [BANK_W-1:0]         mem_bank_select;
  logic [DATA_W-1:0]         mem_do;
  logic [DATA_W-1:0]         dev_mem_do;

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_pack
    assign dev_mem_addr[g*ADDR_W +: ADDR_W]    = t_addr[g];
    assign dev_mem_di[g*DATA_W +: DATA_W]      = t_di[g];
    assign dev_bank_select[g*BANK_W +: BANK_W] = t_bank[g];
  end

  mem_arbiter_rr #(
    .NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BANK_W(BANK_W), .BURST_LEN(BURST_LEN), .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk(clk), .reset(rst),
    .dev_mem_en(t_en), .dev_mem_we(t_we), .dev_burst_en(t_bst),
    .dev_mem_addr(dev_mem_addr), .dev_mem_di(dev_mem_di),
    .dev_bank_select(dev_bank_select), .dev_ack(dev_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_bank_select(mem_bank_select), .mem_do(mem_do), .dev_mem_do(dev_mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first RAM that the arbiter drives.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_di;
      mem_do <= ram[mem_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DATA_W-1:0] ref_ram [DEPTH];
  int                m_lg;
  int                m_prev;        // device whose beat is in flight, -1 if none
  logic              m_prev_we;
  logic [ADDR_W-1:0] m_prev_addr;
  logic [DATA_W-1:0] m_prev_di;
  int                m_bowner;
  logic [ADDR_W-1:0] m_bq [$];      // remaining burst addresses for m_bowner

  logic              x_en, x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_di;
  logic [BANK_W-1:0] x_bank;
  logic [NUM_DEV-1:0] x_ack;
  logic              x_rd_valid;
  logic [DATA_W-1:0] x_rdata;

  task automatic model_step();
    int win;
    x_rd_valid = 1'b0;
    x_rdata    = '0;
    if (m_prev >= 0) begin
      if (m_prev_we) ref_ram[m_prev_addr] = m_prev_di;
      else x_rdata = ref_ram[m_prev_addr];
    end
    x_en = 1'b0; x_we = 1'b0; x_addr = '0; x_di = '0; x_bank = '0; x_ack = '0;
    if (!rst) begin
      m_lg = NUM_DEV - 1;
      m_prev = -1;
      m_bq.delete();
      return;
    end
    if (m_prev >= 0) begin
      x_ack[m_prev] = 1'b1;
      x_rd_valid = !m_prev_we;
    end
    win = -1;
    if (m_bq.size() > 0 && t_en[m_bowner]) begin
      win = m_bowner;
      x_addr = m_bq.pop_front();
      x_we = 1'b0;
    end else begin
      m_bq.delete();
      for (int k = 1; k <= NUM_DEV; k++) begin
        int d;
        d = (m_lg + k) % NUM_DEV;
        if (win < 0 && t_en[d] && d != m_prev) win = d;
      end
      if (win >= 0) begin
        m_lg = win;
        m_bowner = win;
        x_addr = t_addr[win];
        x_we = t_we[win];
        if (t_bst[win] && !t_we[win])
          for (int s = 1; s < BURST_LEN; s++)
            m_bq.push_back(ADDR_W'(32'(t_addr[win]) + 32'(s) * ADDR_STEP));
      end
    end
    if (win >= 0) begin
      x_en = 1'b1;
      x_di = t_di[win];
      x_bank = t_bank[win];
      m_prev_we = x_we;
      m_prev_addr = x_addr;
      m_prev_di = x_di;
    end
    m_prev = win;
  endtask

  // One clock: predict, advance, then compare full output set at the negedge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model_outputs",
        64'({mem_en, mem_we, mem_addr, mem_di, mem_bank_select, dev_ack}),
        64'({x_en, x_we, x_addr, x_di, x_bank, x_ack}));
    if (x_rd_valid) chk("model_rdata", 64'(dev_mem_do), 64'(x_rdata));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               rst_n;
    logic [NUM_DEV-1:0] en, we, bst;
    logic [ADDR_W-1:0]  a0, a1, a2;
    logic               x_en, x_we;
    logic [ADDR_W-1:0]  x_addr;
    logic [NUM_DEV-1:0] x_ack;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic r, input logic [2:0] en, input logic [2:0] we,
                              input logic [2:0] bst, input logic [9:0] a0, input logic [9:0] a1,
                              input logic [9:0] a2, input logic xen, input logic xwe,
                              input logic [9:0] xaddr, input logic [2:0] xack);
    vec_t v;
    v.rst_n = r; v.en = en; v.we = we; v.bst = bst;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.x_en = xen; v.x_we = xwe; v.x_addr = xaddr; v.x_ack = xack;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
      ref_ram[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    end
    mem_do = '0;
    rst = 1'b0;
    t_en = '0; t_we = '0; t_bst = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      t_addr[i] = '0;
      t_di[i]   = 32'hD000_0000 | 32'(i);
      t_bank[i] = BANK_W'(i + 1);
    end
    m_lg = NUM_DEV - 1; m_prev = -1; m_bowner = 0;
    m_prev_we = 1'b0; m_prev_addr = '0; m_prev_di = '0;

    // reset, then dev 1 single read of 0x010
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    vecs.push_back(mk(1, 3'b010, 3'b000, 3'b000, 10'h000, 10'h010, 10'h000, 1, 0, 10'h010, 3'b000));
    vecs.push_back(mk(1, 3'b010, 3'b000, 3'b000, 10'h000, 10'h010, 10'h000, 0, 0, 10'h000, 3'b010));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // lone requester served every other cycle
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b000, 10'h020, 10'h000, 10'h000, 1, 0, 10'h020, 3'b000));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b000, 10'h020, 10'h000, 10'h000, 0, 0, 10'h000, 3'b001));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b000, 10'h020, 10'h000, 10'h000, 1, 0, 10'h020, 3'b000));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b000, 10'h020, 10'h000, 10'h000, 0, 0, 10'h000, 3'b001));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // dev 0 burst wrapping past the top of the address space
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h3F8, 10'h000, 10'h000, 1, 0, 10'h3F8, 3'b000));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h3F8, 10'h000, 10'h000, 1, 0, 10'h3FC, 3'b001));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h3F8, 10'h000, 10'h000, 1, 0, 10'h000, 3'b001));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h3F8, 10'h000, 10'h000, 1, 0, 10'h004, 3'b001));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h3F8, 10'h000, 10'h000, 0, 0, 10'h000, 3'b001));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // dev 2 burst aborted after its 2nd ack: 3 beats total
    vecs.push_back(mk(1, 3'b100, 3'b000, 3'b100, 10'h000, 10'h000, 10'h100, 1, 0, 10'h100, 3'b000));
    vecs.push_back(mk(1, 3'b100, 3'b000, 3'b100, 10'h000, 10'h000, 10'h100, 1, 0, 10'h104, 3'b100));
    vecs.push_back(mk(1, 3'b100, 3'b000, 3'b100, 10'h000, 10'h000, 10'h100, 1, 0, 10'h108, 3'b100));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b100, 10'h000, 10'h000, 10'h100, 0, 0, 10'h000, 3'b100));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // dev 1 write with burst_en: a single write beat
    vecs.push_back(mk(1, 3'b010, 3'b010, 3'b010, 10'h000, 10'h040, 10'h000, 1, 1, 10'h040, 3'b000));
    vecs.push_back(mk(1, 3'b010, 3'b010, 3'b010, 10'h000, 10'h040, 10'h000, 0, 0, 10'h000, 3'b010));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // reset on the 2nd burst beat; dev 0 regains top priority afterwards
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h200, 10'h000, 10'h000, 1, 0, 10'h200, 3'b000));
    vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 10'h200, 10'h000, 10'h000, 1, 0, 10'h204, 3'b001));
    vecs.push_back(mk(0, 3'b001, 3'b000, 3'b001, 10'h200, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));
    // all three contend with single reads for 12 cycles: order 0,1,2,...
    for (int j = 0; j < 12; j++) begin
      logic [2:0] xa;
      xa = (j == 0) ? 3'b000 : 3'(1 << ((j - 1) % 3));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, 10'h300, 10'h310, 10'h320,
                        1, 0, 10'(10'h300 + 10'(16 * (j % 3))), xa));
    end
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b100));
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 3'b000));

    @(negedge clk);
    for (int v = 0; v < vecs.size(); v++) begin
      rst = vecs[v].rst_n;
      t_en = vecs[v].en; t_we = vecs[v].we; t_bst = vecs[v].bst;
      t_addr[0] = vecs[v].a0; t_addr[1] = vecs[v].a1; t_addr[2] = vecs[v].a2;
      cycle();
      chk($sformatf("vec%0d", v),
          64'({mem_en, mem_we, mem_addr, dev_ack}),
          64'({vecs[v].x_en, vecs[v].x_we, vecs[v].x_addr, vecs[v].x_ack}));
    end

    // randomized traffic against the model, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) != 0);
      for (int i = 0; i < NUM_DEV; i++) begin
        if ($urandom_range(0, 5) == 0) t_en[i] = ~t_en[i];
        if (!t_en[i] || $urandom_range(0, 7) == 0) begin
          t_addr[i] = ADDR_W'($urandom);
          t_we[i]   = ($urandom_range(0, 3) == 0);
          t_bst[i]  = $urandom_range(0, 1) == 1;
        end
        t_di[i]   = DATA_W'($urandom);
        t_bank[i] = BANK_W'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised round-robin memory arbiter with read bursts. It multiplexes NUM_DEV requesters onto one synchronous single-port RAM and is the successor to the fixed three-device memory controller. It generalises device count, address, data and bank widths, and burst length. It adds fair rotating priority, fixed-length pipelined read bursts, and a per-beat acknowledge aligned to RAM read data. It sits between the CPU-side masters (fetch, load/store, DMA) and the `ram` instance, which lives outside this block.

## Interface
Parameters:
- NUM_DEV, 3: number of requesting devices (2..8).
- ADDR_W, 10: RAM address width.
- DATA_W, 32: data width.
- BANK_W, 4: bank/byte-select width.
- BURST_LEN, 4: beats per burst (1..16).
- ADDR_STEP, 4: address increment per burst beat.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- dev_mem_en  in  NUM_DEV  per-device request; held until the device's last ack.
- dev_mem_we  in  NUM_DEV  per-device write enable.
- dev_burst_en  in  NUM_DEV  request a BURST_LEN-beat read burst.
- dev_mem_addr  in  NUM_DEV*ADDR_W  packed addresses, device i at [i*ADDR_W +: ADDR_W].
- dev_mem_di  in  NUM_DEV*DATA_W  packed write data.
- dev_bank_select  in  NUM_DEV*BANK_W  packed bank selects.
- dev_ack  out  NUM_DEV  one-hot; high for the cycle in which mem_do holds that device's beat (write: write completed).
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_di  out  DATA_W  RAM write data.
- mem_bank_select  out  BANK_W  RAM bank select.
- mem_do  in  DATA_W  RAM read data, valid the cycle after RAM samples.
- dev_mem_do  out  DATA_W  mem_do passed through combinationally for all devices.

## Operation
- All mem_* outputs and dev_ack are registered.
- A beat is issued by registering mem_en=1 plus the owner's addr/di/we/bank_select. dev_ack[owner] is registered one cycle later, only if that beat was issued.
- Eligibility rules:
  - Device i is eligible when dev_mem_en[i]=1.
  - A device with a beat issued in the immediately preceding cycle is not eligible, because its request is still high awaiting ack.
  - Consequence: a lone single-beat requester is served at most every other cycle.
- Round-robin:
  - The search starts at last_grant+1 and wraps modulo NUM_DEV; the first eligible device wins.
  - last_grant updates on every new grant, not on burst continuation beats.
  - Reset value of last_grant is NUM_DEV-1, so device 0 has first priority after reset.
- States:
  - IDLE → SINGLE: a grant with burst_en=0 or we=1. Writes never burst.
  - IDLE → BURST: a grant with burst_en=1 and we=0. beat_cnt=1 and base address is latched.
  - SINGLE: one beat issued. Next cycle it arbitrates again (owner excluded) → IDLE/SINGLE/BURST.
  - BURST: each cycle, while dev_mem_en[owner]=1 and beat_cnt<BURST_LEN:
    - issue mem_addr = base + beat_cnt*ADDR_STEP, truncated to ADDR_W (wraps modulo 2^ADDR_W);
    - increment beat_cnt.
  - BURST exit, last beat issued: arbitrate like SINGLE.
  - BURST exit, dev_mem_en[owner] dropped: abort. No further beats are issued; the beat already in flight is still acked. Arbitrate among the other devices that cycle.
- When no beat is issued:
  - mem_en=0, mem_we=0, mem_addr=0, mem_di=0, mem_bank_select=0.
  - dev_ack=0 in the following cycle.
- Reset (reset=0 at an edge):
  - All outputs above go to 0, state goes to IDLE, beat_cnt=0, last_grant=NUM_DEV-1.
  - An in-flight beat is discarded; its ack is suppressed.
  - dev_mem_do still follows mem_do.

## Timing
- Request sampled at edge E0 → mem_en high after E0 → RAM samples at E1 → dev_ack and mem_do valid after E1.
- Single-beat latency from request to ack is 2 cycles.
- Burst: acks on BURST_LEN consecutive cycles, starting 2 cycles after the request.
- Burst throughput is 1 beat/cycle; single-beat throughput for one device is 1 beat/2 cycles.
- Arbitration is never stalled: a new grant may be issued in the same cycle a previous owner's ack is high.
- Simultaneous requests from all devices are served in order last_grant+1, +2, … with no starvation. Worst-case wait is (NUM_DEV-1)*BURST_LEN cycles.

## Test plan
- Reset to single read:
  - Stimulus: release reset; dev 1 reads addr 0x010.
  - Required: mem_en high at cycle 1 with mem_addr=0x010; dev_ack=3'b010 at cycle 2; dev_mem_do equals RAM content.
- All-device contention:
  - Stimulus: NUM_DEV=3, all three request single reads every cycle for 12 cycles.
  - Required: grant order 0,1,2,0,1,2…; every device acked exactly once per 3 issues.
- Read burst with wrap:
  - Stimulus: BURST_LEN=4, ADDR_STEP=4, ADDR_W=10; dev 0 bursts from 0x3F8.
  - Required: mem_addr sequence 0x3F8, 0x3FC, 0x000, 0x004; four consecutive acks on dev 0.
- Burst abort and write-with-burst_en:
  - Stimulus A: dev 2 drops mem_en after its 2nd ack.
  - Required A: exactly 3 beats issued (2 acked plus 1 in flight, also acked).
  - Stimulus B: dev 1 write with burst_en=1.
  - Required B: a single beat with mem_we=1.
- Lone requester spacing:
  - Stimulus: dev 0 holds mem_en with burst_en=0.
  - Required: mem_en toggles 1,0,1,0; dev_ack[0] on alternating cycles.
- Reset mid-burst:
  - Stimulus: reset=0 on the 2nd burst beat.
  - Required: next cycle all outputs are 0 with no ack; after release, device 0 has top priority.
